// File: rtl/xgs_athena_system_top.sv
// xgs_athena_system_top: AXI-Lite register slave plus a triggered frame generator
// that streams synthetic sensor beats on AXI-Stream and raises a frame-done interrupt.
module xgs_athena_system_top #(
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 11,
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_USER_WIDTH = 4
) (
  input  logic                         aclk,
  input  logic                         aclk_reset_n,
  input  logic [AXIL_ADDR_WIDTH-1:0]   aclk_awaddr,
  input  logic [2:0]                   aclk_awprot,
  input  logic                         aclk_awvalid,
  output logic                         aclk_awready,
  input  logic [AXIL_DATA_WIDTH-1:0]   aclk_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0] aclk_wstrb,
  input  logic                         aclk_wvalid,
  output logic                         aclk_wready,
  output logic [1:0]                   aclk_bresp,
  output logic                         aclk_bvalid,
  input  logic                         aclk_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0]   aclk_araddr,
  input  logic [2:0]                   aclk_arprot,
  input  logic                         aclk_arvalid,
  output logic                         aclk_arready,
  output logic [AXIL_DATA_WIDTH-1:0]   aclk_rdata,
  output logic [1:0]                   aclk_rresp,
  output logic                         aclk_rvalid,
  input  logic                         aclk_rready,
  output logic [AXIS_DATA_WIDTH-1:0]   s_axis_tx_tdata,
  output logic [AXIS_USER_WIDTH-1:0]   s_axis_tx_tuser,
  output logic                         s_axis_tx_tlast,
  output logic                         s_axis_tx_tvalid,
  input  logic                         s_axis_tx_tready,
  output logic                         irq_dma,
  input  logic [1:0]                   XGSmodel_sel,
  input  logic                         anput_ext_trig
);
  localparam int AW = AXIL_ADDR_WIDTH - 2;
  localparam logic [AW-1:0] A_ID = AW'(0), A_VER = AW'(1), A_SCRATCH = AW'(2), A_CTRL = AW'(4),
                            A_SWTRIG = AW'(5), A_SIZE = AW'(6), A_STATUS = AW'(7), A_MISSED = AW'(9);
  typedef enum logic {S_IDLE, S_STREAM} state_t;
  state_t r_state, w_next;
  logic r_live, r_aw_cap, r_w_cap, r_bvalid, r_rvalid, r_irq_pend, r_irq;
  logic [AW-1:0] r_waddr;
  logic [31:0] r_wdata, r_rdata, r_scratch, r_img_size, w_rd, w_mask;
  logic [3:0] r_wstrb, w_user;
  logic [2:0] r_ctrl, r_sync;
  logic [15:0] r_frame_cnt, r_missed, r_line, r_beat, r_lines, r_beats;
  logic [1:0] r_sel;
  logic w_wr, w_busy, w_last, w_eof, w_hs, w_eof_hs, w_sw_trig, w_ext_trig, w_trig, w_start, w_unused;
  logic [AW-1:0] w_ra;
  assign w_unused = &{1'b0, aclk_awprot, aclk_arprot, aclk_awaddr[1:0], aclk_araddr[1:0]};
  assign w_ra = aclk_araddr[AXIL_ADDR_WIDTH-1:2];
  assign w_wr = r_aw_cap & r_w_cap;
  assign w_mask = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
  assign w_busy = r_state == S_STREAM;
  assign w_last = r_beat == r_beats - 16'd1;
  assign w_eof = w_last && r_line == r_lines - 16'd1;
  assign w_hs = w_busy & s_axis_tx_tready;
  assign w_eof_hs = w_hs & w_eof;
  assign w_sw_trig = w_wr && r_waddr == A_SWTRIG && r_wstrb[0] && r_wdata[0];
  assign w_ext_trig = r_sync[1] & ~r_sync[2];
  assign w_trig = r_ctrl[1] ? w_ext_trig : w_sw_trig;
  assign w_start = w_trig & ~w_busy & r_ctrl[0] & (|r_img_size[15:0]) & (|r_img_size[31:16]);
  assign aclk_awready = r_live & ~r_aw_cap & ~r_bvalid;
  assign aclk_wready = r_live & ~r_w_cap & ~r_bvalid;
  assign aclk_arready = r_live & ~r_rvalid;
  assign aclk_bvalid = r_bvalid;
  assign aclk_bresp = 2'b00;
  assign aclk_rvalid = r_rvalid;
  assign aclk_rdata = r_rdata;
  assign aclk_rresp = 2'b00;
  assign irq_dma = r_irq;
  assign w_user = w_busy ? {1'b0, w_eof, r_beat == 16'd0, r_beat == 16'd0 && r_line == 16'd0} : 4'd0;
  assign s_axis_tx_tvalid = w_busy;
  assign s_axis_tx_tlast = w_busy & w_last;
  assign s_axis_tx_tuser = w_user;
  assign s_axis_tx_tdata = {r_frame_cnt, r_line, r_beat, 14'd0, r_sel};
  always_comb begin
    w_next = w_start ? S_STREAM : w_eof_hs ? S_IDLE : r_state;
    case (w_ra)
      A_ID:      w_rd = 32'h5847_5341;
      A_VER:     w_rd = 32'h0001_0000;
      A_SCRATCH: w_rd = r_scratch;
      A_CTRL:    w_rd = {29'd0, r_ctrl};
      A_SIZE:    w_rd = r_img_size;
      A_STATUS:  w_rd = {r_frame_cnt, 14'd0, r_irq_pend, w_busy};
      A_MISSED:  w_rd = {16'd0, r_missed};
      default:   w_rd = 32'd0;
    endcase
  end
  always_ff @(posedge aclk or negedge aclk_reset_n)
    if (!aclk_reset_n) begin
      r_live <= 1'b0;
      r_aw_cap <= 1'b0;
      r_w_cap <= 1'b0;
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
    end else begin
      r_live <= 1'b1;
      if (aclk_awvalid && aclk_awready) begin
        r_aw_cap <= 1'b1;
        r_waddr <= aclk_awaddr[AXIL_ADDR_WIDTH-1:2];
      end
      if (aclk_wvalid && aclk_wready) begin
        r_w_cap <= 1'b1;
        r_wdata <= aclk_wdata;
        r_wstrb <= aclk_wstrb;
      end
      if (w_wr) begin
        r_aw_cap <= 1'b0;
        r_w_cap <= 1'b0;
        r_bvalid <= 1'b1;
      end else if (aclk_bready) r_bvalid <= 1'b0;
      if (aclk_arvalid && aclk_arready) begin
        r_rvalid <= 1'b1;
        r_rdata <= w_rd;
      end else if (aclk_rready) r_rvalid <= 1'b0;
    end
  always_ff @(posedge aclk or negedge aclk_reset_n)
    if (!aclk_reset_n) begin
      r_scratch <= '0;
      r_ctrl <= '0;
      r_img_size <= '0;
      r_irq_pend <= 1'b0;
      r_irq <= 1'b0;
      r_frame_cnt <= '0;
      r_missed <= '0;
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], anput_ext_trig};
      if (w_wr && r_waddr == A_SCRATCH) r_scratch <= (r_scratch & ~w_mask) | (r_wdata & w_mask);
      if (w_wr && r_waddr == A_CTRL) r_ctrl <= (r_ctrl & ~w_mask[2:0]) | (r_wdata[2:0] & w_mask[2:0]);
      if (w_wr && r_waddr == A_SIZE) r_img_size <= (r_img_size & ~w_mask) | (r_wdata & w_mask);
      // a frame ending in the same cycle as the W1C keeps the interrupt pending
      if (w_eof_hs) r_irq_pend <= 1'b1;
      else if (w_wr && r_waddr == A_STATUS && r_wstrb[0] && r_wdata[1]) r_irq_pend <= 1'b0;
      r_irq <= r_irq_pend & r_ctrl[2];
      if (w_eof_hs) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_trig && !w_start && r_missed != 16'hFFFF) r_missed <= r_missed + 16'd1;
    end
  always_ff @(posedge aclk or negedge aclk_reset_n)
    if (!aclk_reset_n) begin
      r_state <= S_IDLE;
      r_line <= '0;
      r_beat <= '0;
      r_lines <= '0;
      r_beats <= '0;
      r_sel <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_line <= '0;
        r_beat <= '0;
        r_lines <= r_img_size[31:16];
        r_beats <= r_img_size[15:0];
        r_sel <= XGSmodel_sel;
      end else if (w_hs) begin
        r_beat <= w_last ? 16'd0 : r_beat + 16'd1;
        if (w_last) r_line <= r_line + 16'd1;
      end
    end
endmodule

// File: tb/tb_xgs_athena_system_top.sv
// tb_xgs_athena_system_top: register vectors and frame vectors checked through a beat scoreboard.
module tb_xgs_athena_system_top;
  logic aclk = 0, aclk_reset_n = 0;
  logic [10:0] aclk_awaddr = 0, aclk_araddr = 0;
  logic [2:0] aclk_awprot = 0, aclk_arprot = 0;
  logic aclk_awvalid = 0, aclk_awready, aclk_wvalid = 0, aclk_wready, aclk_bvalid, aclk_bready = 0;
  logic aclk_arvalid = 0, aclk_arready, aclk_rvalid, aclk_rready = 0;
  logic [31:0] aclk_wdata = 0, aclk_rdata;
  logic [3:0] aclk_wstrb = 0, s_axis_tx_tuser;
  logic [1:0] aclk_bresp, aclk_rresp, XGSmodel_sel = 0;
  logic [63:0] s_axis_tx_tdata;
  logic s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tready = 1, irq_dma, anput_ext_trig = 0;
  xgs_athena_system_top dut (
    .aclk(aclk), .aclk_reset_n(aclk_reset_n),
    .aclk_awaddr(aclk_awaddr), .aclk_awprot(aclk_awprot), .aclk_awvalid(aclk_awvalid), .aclk_awready(aclk_awready),
    .aclk_wdata(aclk_wdata), .aclk_wstrb(aclk_wstrb), .aclk_wvalid(aclk_wvalid), .aclk_wready(aclk_wready),
    .aclk_bresp(aclk_bresp), .aclk_bvalid(aclk_bvalid), .aclk_bready(aclk_bready),
    .aclk_araddr(aclk_araddr), .aclk_arprot(aclk_arprot), .aclk_arvalid(aclk_arvalid), .aclk_arready(aclk_arready),
    .aclk_rdata(aclk_rdata), .aclk_rresp(aclk_rresp), .aclk_rvalid(aclk_rvalid), .aclk_rready(aclk_rready),
    .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tuser(s_axis_tx_tuser), .s_axis_tx_tlast(s_axis_tx_tlast),
    .s_axis_tx_tvalid(s_axis_tx_tvalid), .s_axis_tx_tready(s_axis_tx_tready),
    .irq_dma(irq_dma), .XGSmodel_sel(XGSmodel_sel), .anput_ext_trig(anput_ext_trig)
  );
  always #5 aclk = ~aclk;
  int errors = 0, checks = 0, mode = 0, hs_cnt = 0;
  typedef struct {logic [63:0] d; logic [3:0] u; logic l;} beat_t;
  beat_t q[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  // scoreboard: every beat handshake pops one expected beat; stalled beats must hold still
  logic stalled = 0;
  logic [63:0] held_d;
  logic [4:0] held_ul;
  always @(negedge aclk) begin
    if (aclk_reset_n && s_axis_tx_tvalid) begin
      if (stalled) begin
        chk("stall_data", s_axis_tx_tdata, held_d);
        chk("stall_user_last", {s_axis_tx_tuser, s_axis_tx_tlast}, held_ul);
      end
      if (s_axis_tx_tready) begin
        stalled = 0;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%h expected=none", s_axis_tx_tdata);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("beat_data", s_axis_tx_tdata, e.d);
          chk("beat_tuser", s_axis_tx_tuser, e.u);
          chk("beat_tlast", s_axis_tx_tlast, e.l);
          hs_cnt++;
        end
      end else begin
        stalled = 1;
        held_d = s_axis_tx_tdata;
        held_ul = {s_axis_tx_tuser, s_axis_tx_tlast};
      end
    end else stalled = 0;
  end
  initial forever begin
    @(posedge aclk);
    #1;
    if (mode == 0) s_axis_tx_tready = 1;
    else if (mode == 1) s_axis_tx_tready = ~s_axis_tx_tready;
  end
  task automatic wait_b;
    bit got = 0;
    aclk_bready = 1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge aclk);
      if (aclk_bvalid) begin
        got = 1;
        chk("bresp", aclk_bresp, 0);
      end
      @(posedge aclk);
      #1;
    end
    aclk_bready = 0;
    chk("b_handshake", got, 1);
  endtask
  task automatic axi_wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s);
    logic ah, wh;
    @(posedge aclk);
    #1;
    aclk_awaddr = a; aclk_wdata = d; aclk_wstrb = s; aclk_awvalid = 1; aclk_wvalid = 1;
    for (int k = 0; k < 50 && (aclk_awvalid || aclk_wvalid); k++) begin
      @(negedge aclk);
      ah = aclk_awvalid & aclk_awready;
      wh = aclk_wvalid & aclk_wready;
      @(posedge aclk);
      #1;
      if (ah) aclk_awvalid = 0;
      if (wh) aclk_wvalid = 0;
    end
    chk("aw_w_handshake", {aclk_awvalid, aclk_wvalid}, 0);
    aclk_awvalid = 0; aclk_wvalid = 0;
    wait_b();
  endtask
  task automatic axi_rd(input logic [10:0] a, output logic [31:0] d);
    logic h;
    bit got = 0;
    d = 0;
    @(posedge aclk);
    #1;
    aclk_araddr = a; aclk_arvalid = 1;
    for (int k = 0; k < 50 && aclk_arvalid; k++) begin
      @(negedge aclk);
      h = aclk_arready;
      @(posedge aclk);
      #1;
      if (h) aclk_arvalid = 0;
    end
    aclk_arvalid = 0;
    aclk_rready = 1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge aclk);
      if (aclk_rvalid) begin
        got = 1;
        d = aclk_rdata;
        chk("rresp", aclk_rresp, 0);
      end
      @(posedge aclk);
      #1;
    end
    aclk_rready = 0;
    chk("r_handshake", got, 1);
  endtask
  task automatic rd_chk(input string name, input logic [10:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_rd(a, d);
    chk(name, d, exp);
  endtask
  task automatic push_frame(input logic [15:0] fc, input logic [15:0] lines, input logic [15:0] beats, input logic [1:0] sel);
    beat_t b;
    for (int l = 0; l < int'(lines); l++)
      for (int i = 0; i < int'(beats); i++) begin
        b.d = {fc, 16'(l), 16'(i), 14'd0, sel};
        b.u = {1'b0, l == int'(lines) - 1 && i == int'(beats) - 1, i == 0, l == 0 && i == 0};
        b.l = i == int'(beats) - 1;
        q.push_back(b);
      end
  endtask
  task automatic wait_frame;
    for (int k = 0; k < 3000 && q.size() != 0; k++) @(posedge aclk);
    chk("frame_done", q.size(), 0);
    repeat (3) @(posedge aclk);
    #1;
  endtask
  typedef struct {logic [10:0] wa; logic [31:0] wd; logic [3:0] ws; logic [10:0] ra; logic [31:0] exp;} reg_v_t;
  typedef struct {logic [15:0] lines; logic [15:0] beats; logic [1:0] sel; int m;} frm_v_t;
  reg_v_t rv[7];
  frm_v_t fv[4];
  logic [15:0] fc = 0;
  initial begin
    rv[0] = '{11'h008, 32'hA5A5_5A5A, 4'b0011, 11'h008, 32'h0000_5A5A};
    rv[1] = '{11'h008, 32'hFFFF_FFFF, 4'b1100, 11'h008, 32'hFFFF_5A5A};
    rv[2] = '{11'h00A, 32'hDEAD_BEEF, 4'b1111, 11'h009, 32'hDEAD_BEEF};
    rv[3] = '{11'h000, 32'h1234_5678, 4'b1111, 11'h000, 32'h5847_5341};
    rv[4] = '{11'h004, 32'h0000_0000, 4'b1111, 11'h004, 32'h0001_0000};
    rv[5] = '{11'h040, 32'hFFFF_FFFF, 4'b1111, 11'h040, 32'h0000_0000};
    rv[6] = '{11'h014, 32'hFFFF_FFFE, 4'b1111, 11'h014, 32'h0000_0000};
    fv[0] = '{16'd2, 16'd4, 2'd2, 0};
    fv[1] = '{16'd2, 16'd4, 2'd2, 1};
    fv[2] = '{16'd1, 16'd1, 2'd0, 0};
    fv[3] = '{16'd3, 16'd2, 2'd1, 1};
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_readies", {aclk_awready, aclk_wready, aclk_arready}, 0);
    chk("rst_valids", {aclk_bvalid, aclk_rvalid, s_axis_tx_tvalid, s_axis_tx_tlast, irq_dma}, 0);
    chk("rst_tuser", s_axis_tx_tuser, 0);
    @(posedge aclk);
    #1;
    aclk_reset_n = 1;
    @(negedge aclk);
    chk("awready_at_release", aclk_awready, 0);
    @(negedge aclk);
    chk("readies_after_release", {aclk_awready, aclk_wready, aclk_arready}, 3'b111);
    rd_chk("id", 11'h000, 32'h5847_5341);
    rd_chk("version", 11'h004, 32'h0001_0000);
    rd_chk("status_rst", 11'h01C, 0);
    for (int i = 0; i < 7; i++) begin
      axi_wr(rv[i].wa, rv[i].wd, rv[i].ws);
      rd_chk($sformatf("reg_vec%0d", i), rv[i].ra, rv[i].exp);
    end
    rd_chk("missed_none", 11'h024, 0);
    for (int i = 0; i < 4; i++) begin
      axi_wr(11'h018, {fv[i].lines, fv[i].beats}, 4'hF);
      axi_wr(11'h010, 32'h5, 4'hF);
      XGSmodel_sel = fv[i].sel;
      mode = fv[i].m;
      push_frame(fc, fv[i].lines, fv[i].beats, fv[i].sel);
      axi_wr(11'h014, 32'h1, 4'hF);
      XGSmodel_sel = ~fv[i].sel;
      wait_frame();
      mode = 0;
      fc++;
      rd_chk($sformatf("status_eof%0d", i), 11'h01C, {fc, 16'h0002});
      chk($sformatf("irq_set%0d", i), irq_dma, 1);
      axi_wr(11'h01C, 32'h2, 4'hF);
      repeat (2) @(posedge aclk);
      #1;
      chk($sformatf("irq_clr%0d", i), irq_dma, 0);
      rd_chk($sformatf("status_clr%0d", i), 11'h01C, {fc, 16'h0000});
    end
    axi_wr(11'h018, 32'h0000_0004, 4'hF);
    axi_wr(11'h014, 32'h1, 4'hF);
    axi_wr(11'h018, 32'h0001_0004, 4'hF);
    axi_wr(11'h010, 32'h4, 4'hF);
    axi_wr(11'h014, 32'h1, 4'hF);
    repeat (5) @(posedge aclk);
    #1;
    chk("no_frame_when_blocked", s_axis_tx_tvalid, 0);
    rd_chk("missed_two", 11'h024, 2);
    axi_wr(11'h018, 32'h0004_0008, 4'hF);
    axi_wr(11'h010, 32'h7, 4'hF);
    XGSmodel_sel = 1;
    push_frame(fc, 16'd4, 16'd8, 2'd1);
    anput_ext_trig = 1;
    repeat (5) @(posedge aclk);
    #1;
    anput_ext_trig = 0;
    repeat (10) @(posedge aclk);
    #1;
    chk("ext_mid_frame_busy", s_axis_tx_tvalid, 1);
    anput_ext_trig = 1;
    repeat (5) @(posedge aclk);
    #1;
    anput_ext_trig = 0;
    wait_frame();
    repeat (10) @(posedge aclk);
    #1;
    chk("ext_single_frame", s_axis_tx_tvalid, 0);
    fc++;
    rd_chk("missed_ext", 11'h024, 3);
    rd_chk("status_ext", 11'h01C, {fc, 16'h0002});
    axi_wr(11'h01C, 32'h2, 4'hF);
    axi_wr(11'h010, 32'h5, 4'hF);
    axi_wr(11'h018, 32'h0001_0001, 4'hF);
    mode = 3;
    s_axis_tx_tready = 0;
    XGSmodel_sel = 3;
    push_frame(fc, 16'd1, 16'd1, 2'd3);
    axi_wr(11'h014, 32'h1, 4'hF);
    repeat (2) @(posedge aclk);
    #1;
    chk("eof_stalled", s_axis_tx_tvalid, 1);
    aclk_awaddr = 11'h01C; aclk_wdata = 32'h2; aclk_wstrb = 4'hF; aclk_awvalid = 1; aclk_wvalid = 1;
    @(negedge aclk);
    chk("w1c_readies", {aclk_awready, aclk_wready}, 2'b11);
    @(posedge aclk);
    #1;
    aclk_awvalid = 0; aclk_wvalid = 0;
    s_axis_tx_tready = 1;
    @(posedge aclk);
    #1;
    mode = 0;
    wait_b();
    wait_frame();
    fc++;
    rd_chk("set_wins_w1c", 11'h01C, {fc, 16'h0002});
    axi_wr(11'h01C, 32'h2, 4'hF);
    rd_chk("status_w1c_after", 11'h01C, {fc, 16'h0000});
    axi_wr(11'h018, 32'h0002_0004, 4'hF);
    XGSmodel_sel = 0;
    push_frame(fc, 16'd2, 16'd4, 2'd0);
    hs_cnt = 0;
    axi_wr(11'h014, 32'h1, 4'hF);
    for (int k = 0; k < 100 && hs_cnt < 3; k++) @(posedge aclk);
    #2;
    chk("beat3_present", s_axis_tx_tdata, {fc, 16'd0, 16'd3, 16'd0});
    aclk_reset_n = 0;
    #1;
    chk("async_reset_tvalid", s_axis_tx_tvalid, 0);
    q.delete();
    repeat (3) @(posedge aclk);
    #1;
    aclk_reset_n = 1;
    repeat (10) @(posedge aclk);
    #1;
    chk("no_beat_after_reset", s_axis_tx_tvalid, 0);
    rd_chk("status_after_reset", 11'h01C, 0);
    rd_chk("missed_after_reset", 11'h024, 0);
    rd_chk("ctrl_after_reset", 11'h010, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
